adder_stim_gen: RTL and testbench

- Upstream stimulus stage for the adder DUT.
- Produces pseudo-random operand pairs (a, b) from a 32-bit Galois LFSR, one pair per emit cycle.
- Emits a fixed number of pairs (TRACE_LEN) per run, then stops and flags done.
- Replaces free-running bench randomisation with a reproducible, seedable, stallable source; outputs wire directly to the adder's a/b inputs.

---
 rtl/adder_stim_gen.sv | 136 +++++++++++++
 tb/tb_adder_stim_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adder_stim_gen.sv
// adder_stim_gen
//   Seedable, stallable stimulus source for the adder. A 32-bit Galois LFSR
//   supplies one (a, b) operand pair on each emit cycle. A run emits
//   TRACE_LEN pairs, then the block parks in DONE until the next start.
//
// Parameters
//   WIDTH     operand width, 1..16
//   TRACE_LEN pairs per run, >= 1
//   SEED      LFSR reset value; 0 is replaced by 1 so the LFSR cannot lock up
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a run (acted on in IDLE or DONE only)
//   stall  in   hold emission while high
//   a, b   out  registered operands
//   valid  out  high for exactly the cycles where a/b carry a new pair
//   busy   out  registered, high while in RUN
//   done   out  registered, high while in DONE
//   count  out  pairs emitted in the current run
//
// Build option
//   ADDER_STIM_SHIFT_EN  when defined, a and b are shifted right by 2 after
//                        extraction (top two bits 0); LFSR sequence unchanged.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | emitting one pair per unstalled cycle
// DONE  | TRACE_LEN pairs emitted; outputs held until next start

module adder_stim_gen #(
  parameter int          WIDTH     = 8,
  parameter int          TRACE_LEN = 1000,
  parameter logic [31:0] SEED      = 32'hACE12468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      count
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [31:0] LAST     = 32'(TRACE_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        lfsr, lfsr_nxt, lfsr_step;
  logic [WIDTH-1:0]   field_a, field_b;
  logic [WIDTH-1:0]   a_nxt, b_nxt;
  logic               valid_nxt;
  logic [31:0]        count_nxt, count_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
    count_inc = count + 32'd1;

`ifdef ADDER_STIM_SHIFT_EN
    field_a = lfsr[WIDTH-1:0] >> 2;
    field_b = lfsr[2*WIDTH-1:WIDTH] >> 2;
`else
    field_a = lfsr[WIDTH-1:0];
    field_b = lfsr[2*WIDTH-1:WIDTH];
`endif

    state_nxt = state;
    lfsr_nxt  = lfsr;
    a_nxt     = a;
    b_nxt     = b;
    valid_nxt = 1'b0;
    count_nxt = count;

    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // A stalled final emit simply waits; DONE is only reached by an emit.
        if (!stall) begin
          a_nxt     = field_a;
          b_nxt     = field_b;
          valid_nxt = 1'b1;
          lfsr_nxt  = lfsr_step;
          count_nxt = count_inc;
          if (count_inc == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        // No reseed: a new run continues the LFSR sequence.
        if (start) begin
          state_nxt = RUN;
          count_nxt = 32'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= SEED_EFF;
      a     <= '0;
      b     <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= 32'd0;
    end else begin
      lfsr  <= lfsr_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      valid <= valid_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_adder_stim_gen.sv
module tb_adder_stim_gen;

  localparam int          W    = 8;
  localparam int          TL   = 4;
  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] POLY = 32'h80200003;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [W-1:0]  a, b;
  logic          valid, busy, done;
  logic [31:0]   count;

  int total = 0;
  int bad   = 0;

  adder_stim_gen #(.WIDTH(W), .TRACE_LEN(TL), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .a(a), .b(b), .valid(valid), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ext(input logic [7:0] v);
`ifdef ADDER_STIM_SHIFT_EN
    return v >> 2;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] next_lfsr(input logic [31:0] x);
    if (x % 2 == 1) return (x / 2) ^ POLY;
    return x / 2;
  endfunction

  // Directed vectors: inputs applied before an edge, expected outputs after it.
  // Expected a/b are raw LFSR fields; ext() applies the optional shift.
  typedef struct {
    logic       rst, start, stall;
    logic       ev;
    logic [7:0] ea, eb;
    int         ec;
    logic       ebusy, edone;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic st,
                              input logic ev, input logic [7:0] ea, input logic [7:0] eb,
                              input int ec, input logic ebusy, input logic edone);
    vec_t v;
    v.rst = r; v.start = s; v.stall = st; v.ev = ev; v.ea = ea; v.eb = eb;
    v.ec = ec; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  vec_t tbl[17];

  // Random-phase reference: the pair sequence is precomputed, a run takes
  // the next TL entries of it, and a reset rewinds to the start.
  logic [31:0] seq[0:4095];

  initial begin
    tbl[0]  = mk(1,0,0, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0,1,0, 0, 8'h00, 8'h00, 0, 1, 0);
    tbl[2]  = mk(0,0,0, 1, 8'h68, 8'h24, 1, 1, 0);
    tbl[3]  = mk(0,0,0, 1, 8'h34, 8'h92, 2, 1, 0);
    tbl[4]  = mk(0,0,1, 0, 8'h34, 8'h92, 2, 1, 0);
    tbl[5]  = mk(0,0,1, 0, 8'h34, 8'h92, 2, 1, 0);
    tbl[6]  = mk(0,1,1, 0, 8'h34, 8'h92, 2, 1, 0);
    tbl[7]  = mk(0,1,0, 1, 8'h1A, 8'h49, 3, 1, 0);
    tbl[8]  = mk(0,0,1, 0, 8'h1A, 8'h49, 3, 1, 0);
    tbl[9]  = mk(0,0,0, 1, 8'h8D, 8'h24, 4, 0, 1);
    tbl[10] = mk(0,0,0, 0, 8'h8D, 8'h24, 4, 0, 1);
    tbl[11] = mk(0,1,0, 0, 8'h8D, 8'h24, 0, 1, 0);
    tbl[12] = mk(0,0,0, 1, 8'h45, 8'h12, 1, 1, 0);
    tbl[13] = mk(0,0,0, 1, 8'h21, 8'h09, 2, 1, 0);
    tbl[14] = mk(1,1,0, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[15] = mk(0,1,0, 0, 8'h00, 8'h00, 0, 1, 0);
    tbl[16] = mk(0,0,0, 1, 8'h68, 8'h24, 1, 1, 0);

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stall = tbl[i].stall;
      tick();
      chk($sformatf("v%0d.valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d.a", i),     32'(a),     32'(tbl[i].rst ? 8'h00 : ext(tbl[i].ea)));
      chk($sformatf("v%0d.b", i),     32'(b),     32'(tbl[i].rst ? 8'h00 : ext(tbl[i].eb)));
      chk($sformatf("v%0d.count", i), count,      32'(tbl[i].ec));
      chk($sformatf("v%0d.busy", i),  32'(busy),  32'(tbl[i].ebusy));
      chk($sformatf("v%0d.done", i),  32'(done),  32'(tbl[i].edone));
    end

    // Directed: four back-to-back emits give exactly four valid cycles.
    begin
      int nv;
      rst = 1; start = 0; stall = 0; tick();
      rst = 0; start = 1; tick();
      start = 0;
      nv = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (valid) nv++;
      end
      chk("burst.valid_cycles", 32'(nv), 32'(TL));
      chk("burst.count_held", count, 32'(TL));
      chk("burst.done", 32'(done), 32'd1);
    end

    // Random phase against the sequence model.
    seq[0] = SEED;
    for (int i = 1; i < 4096; i++) seq[i] = next_lfsr(seq[i-1]);

    begin
      int  ptr;       // index of next pair to emit
      int  in_run;    // pairs emitted in this run, -1 when idle, TL when done
      logic [7:0] ma, mb;
      logic mv;
      rst = 1; start = 0; stall = 0; tick();
      ptr = 0; in_run = -1; ma = 0; mb = 0;
      rst = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic r_rst, r_start, r_stall;
        r_rst   = ($urandom_range(0, 199) == 0);
        r_start = ($urandom_range(0, 3) == 0);
        r_stall = ($urandom_range(0, 2) == 0);
        mv = 0;
        if (r_rst) begin
          ptr = 0; in_run = -1; ma = 0; mb = 0;
        end else if (in_run < 0 || in_run == TL) begin
          if (r_start) in_run = 0;
        end else if (!r_stall) begin
          ma = ext(seq[ptr][7:0]);
          mb = ext(seq[ptr][15:8]);
          mv = 1;
          ptr++;
          in_run++;
        end
        rst = r_rst; start = r_start; stall = r_stall;
        tick();
        chk("rand.valid", 32'(valid), 32'(mv));
        chk("rand.a", 32'(a), 32'(ma));
        chk("rand.b", 32'(b), 32'(mb));
        chk("rand.count", count, 32'(in_run < 0 ? 0 : in_run));
        chk("rand.busy", 32'(busy), 32'(in_run >= 0 && in_run < TL));
        chk("rand.done", 32'(done), 32'(in_run == TL));
      end
      rst = 0; start = 0; stall = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
